// File: rtl/fact_pkg.sv
// Shared definitions for the factorial sequencer: state encoding and the
// default operand/result widths used by the top level and its interface.
package fact_pkg;

  localparam int unsigned FACT_SIZE     = 8;
  localparam int unsigned FACT_OUT_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fact_ctrl_if.sv
// Host-side handshake for the factorial sequencer. The host (master) issues
// start/n and observes busy/done/result/overflow; fact_ctrl is the slave.
interface fact_ctrl_if
  import fact_pkg::*;
#(
  parameter int unsigned SIZE     = FACT_SIZE,
  parameter int unsigned OUT_SIZE = FACT_OUT_SIZE
);

  logic                start;
  logic [SIZE-1:0]     n;
  logic                busy;
  logic                done;
  logic [OUT_SIZE-1:0] result;
  logic                overflow;

  modport master (
    output start, n,
    input  busy, done, result, overflow
  );

  modport slave (
    input  start, n,
    output busy, done, result, overflow
  );

endinterface

// File: rtl/fact_ctrl_cmp.sv
// Existing magnitude comparator used for loop termination: gt = (a > b).
module cmp #(
  parameter int unsigned SIZE = 9
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            gt
);

  // Unsigned magnitude compare.
  always_comb gt = (a > b);

endmodule

// File: rtl/fact_ctrl.sv
// Iterative factorial sequencer: latches n on start, multiplies acc by cnt
// until cnt > n, then returns n! (low OUT_SIZE bits) with a done pulse and
// a sticky overflow flag.
// Build option FACT_CTRL_EARLY_STOP_EN: when defined, the first overflowing
// multiply ends the run immediately with the truncated product as result.
module fact_ctrl
  import fact_pkg::*;
#(
  parameter int unsigned SIZE     = FACT_SIZE,
  parameter int unsigned OUT_SIZE = FACT_OUT_SIZE
) (
  input logic        clk,
  input logic        rst,
  fact_ctrl_if.slave bus
);

  localparam int unsigned PW = OUT_SIZE + SIZE + 1;

  state_t              state, state_nxt;
  logic [SIZE-1:0]     n_reg;
  logic [SIZE:0]       cnt;
  logic [OUT_SIZE-1:0] acc;
  logic [OUT_SIZE-1:0] result_r;
  logic                ovf_r;
  logic                gt;
  logic [PW-1:0]       prod;
  logic                prod_ovf;
  logic                stop_ovf;

  // cnt is one bit wider than n so n = 2^SIZE-1 still terminates.
  cmp #(.SIZE(SIZE + 1)) u_cmp (
    .a  (cnt),
    .b  ({1'b0, n_reg}),
    .gt (gt)
  );

  // Full-width product and detection of bits lost to truncation.
  always_comb begin
    prod     = PW'(acc) * PW'(cnt);
    prod_ovf = |prod[PW-1:OUT_SIZE];
  end

`ifdef FACT_CTRL_EARLY_STOP_EN
  always_comb stop_ovf = prod_ovf;
`else
  always_comb stop_ovf = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; DONE always lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (gt || stop_ovf) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, multiply-accumulate loop and result/overflow update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_reg    <= '0;
      cnt      <= '0;
      acc      <= '0;
      result_r <= '0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            n_reg <= bus.n;
            acc   <= OUT_SIZE'(1);
            cnt   <= (SIZE + 1)'(2);
            ovf_r <= 1'b0;
          end
        end
        RUN: begin
          if (gt) begin
            result_r <= acc;
          end else begin
            acc   <= prod[OUT_SIZE-1:0];
            cnt   <= cnt + (SIZE + 1)'(1);
            ovf_r <= ovf_r | prod_ovf;
            // Early exit publishes the truncated product directly.
            if (stop_ovf) result_r <= prod[OUT_SIZE-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Host-visible status.
  always_comb begin
    bus.busy     = (state != IDLE);
    bus.done     = (state == DONE);
    bus.result   = result_r;
    bus.overflow = ovf_r;
  end

endmodule
